// File: rtl/lc3b_types.sv
// Shared LC-3b types: Wishbone bus widths and the memory arbiter's state/port enums.
package lc3b_types;

  localparam int WB_ADDR_W = 16;
  localparam int WB_DATA_W = 16;
  localparam int WB_SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } lc3b_arb_state;

  typedef enum logic {
    INSTR,
    DATA
  } lc3b_arb_port;

  // A disabled watchdog (timeout 0) still gets a 1-bit counter so it elaborates.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wishbone_arbiter_watchdog.sv
// Saturating wait counter that flags a grant which has waited too long for ACK/RTY.
module arbiter_watchdog
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = wd_width(TIMEOUT_CYCLES);
  localparam int EXP_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] EXP_AT  = EXP_INT[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is only meaningful while waiting, so it is qualified by enable_i.
  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == EXP_AT);

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-port round-robin Wishbone arbiter sharing one memory port between fetch and MEM stage.
module wishbone_arbiter
  import lc3b_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iwb_cyc_i,
  input  logic                 iwb_stb_i,
  input  logic                 iwb_we_i,
  input  logic [WB_SEL_W-1:0]  iwb_sel_i,
  input  logic [WB_ADDR_W-1:0] iwb_adr_i,
  input  logic [WB_DATA_W-1:0] iwb_dat_i,
  output logic [WB_DATA_W-1:0] iwb_dat_o,
  output logic                 iwb_ack_o,
  output logic                 iwb_rty_o,
  input  logic                 dwb_cyc_i,
  input  logic                 dwb_stb_i,
  input  logic                 dwb_we_i,
  input  logic [WB_SEL_W-1:0]  dwb_sel_i,
  input  logic [WB_ADDR_W-1:0] dwb_adr_i,
  input  logic [WB_DATA_W-1:0] dwb_dat_i,
  output logic [WB_DATA_W-1:0] dwb_dat_o,
  output logic                 dwb_ack_o,
  output logic                 dwb_rty_o,
  output logic                 mwb_cyc_o,
  output logic                 mwb_stb_o,
  output logic                 mwb_we_o,
  output logic [WB_SEL_W-1:0]  mwb_sel_o,
  output logic [WB_ADDR_W-1:0] mwb_adr_o,
  output logic [WB_DATA_W-1:0] mwb_dat_o,
  input  logic [WB_DATA_W-1:0] mwb_dat_i,
  input  logic                 mwb_ack_i,
  input  logic                 mwb_rty_i
);

  lc3b_arb_state state_q;
  lc3b_arb_port  last_grant_q;
  logic i_req, d_req, granted, mem_done, owner_cyc, expired;

  assign i_req     = iwb_cyc_i & iwb_stb_i;
  assign d_req     = dwb_cyc_i & dwb_stb_i;
  assign granted   = (state_q != IDLE);
  assign mem_done  = mwb_ack_i | mwb_rty_i;
  assign owner_cyc = (state_q == GRANT_I) ? iwb_cyc_i : dwb_cyc_i;

  arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (!granted),
    .enable_i (granted & ~mem_done),
    .expired_o(expired)
  );

  // On contention the port that did not win last time is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_req && (!d_req || (last_grant_q == DATA))) begin
            state_q      <= GRANT_I;
            last_grant_q <= INSTR;
          end else if (d_req) begin
            state_q      <= GRANT_D;
            last_grant_q <= DATA;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_done || !owner_cyc || expired) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A watchdog expiry drops CYC/STB and answers the owner with RTY in the same cycle.
  always_comb begin
    mwb_cyc_o = 1'b0;
    mwb_stb_o = 1'b0;
    mwb_we_o  = 1'b0;
    mwb_sel_o = '0;
    mwb_adr_o = '0;
    mwb_dat_o = '0;
    iwb_ack_o = 1'b0;
    iwb_rty_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_rty_o = 1'b0;
    case (state_q)
      GRANT_I: begin
        mwb_cyc_o = iwb_cyc_i & ~expired;
        mwb_stb_o = iwb_stb_i & ~expired;
        mwb_we_o  = iwb_we_i;
        mwb_sel_o = iwb_sel_i;
        mwb_adr_o = iwb_adr_i;
        mwb_dat_o = iwb_dat_i;
        iwb_ack_o = mwb_ack_i;
        iwb_rty_o = mwb_rty_i | expired;
      end
      GRANT_D: begin
        mwb_cyc_o = dwb_cyc_i & ~expired;
        mwb_stb_o = dwb_stb_i & ~expired;
        mwb_we_o  = dwb_we_i;
        mwb_sel_o = dwb_sel_i;
        mwb_adr_o = dwb_adr_i;
        mwb_dat_o = dwb_dat_i;
        dwb_ack_o = mwb_ack_i;
        dwb_rty_o = mwb_rty_i | expired;
      end
      default: ;
    endcase
  end

  assign iwb_dat_o = mwb_dat_i;
  assign dwb_dat_o = mwb_dat_i;

endmodule
